// File: rtl/genius_pkg.sv
// genius_pkg: shared states, colours and round limit for the genius game controller
package genius_pkg;
  typedef enum logic [2:0] {OCIOSO, MOSTRA_ON, MOSTRA_OFF, ESPERA, GANHOU, PERDEU} state_e;
  localparam logic [3:0] VERDE      = 4'b0001;
  localparam logic [3:0] VERMELHO   = 4'b0010;
  localparam logic [3:0] AZUL       = 4'b0100;
  localparam logic [3:0] AMARELO    = 4'b1000;
  localparam logic [3:0] TODAS      = VERDE | VERMELHO | AZUL | AMARELO;
  localparam logic [3:0] LAST_ROUND = 4'd15;
endpackage

// File: rtl/genius_timer.sv
// genius_timer: loadable up-counter with clear and terminal-count compare
module genius_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         ld,
  input  logic         en,
  input  logic [W-1:0] ld_val,
  input  logic [W-1:0] term,
  output logic         tc
);
  logic [W-1:0] cnt_d, cnt_q;
  // clear wins over load, load wins over counting
  always_comb cnt_d = clr ? '0 : ld ? ld_val : en ? cnt_q + 1'b1 : cnt_q;
  // count register
  always_ff @(posedge clock) cnt_q <= reset ? '0 : cnt_d;
  assign tc = cnt_q == term;
endmodule

// File: rtl/genius_ctrl.sv
// genius_ctrl: sequence playback / player-echo controller for a four-colour memory game
module genius_ctrl
  import genius_pkg::*;
#(
  parameter int T_ON      = 25_000_000,
  parameter int T_OFF     = 12_500_000,
  parameter int T_TIMEOUT = 250_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] botoes,
  input  logic [3:0] seq_data,
  output logic [3:0] seq_addr,
  output logic [3:0] leds,
  output logic [3:0] rodada,
  output logic       erro,
  output logic       vitoria
);
  localparam int TMAX = (T_ON > T_OFF ? T_ON : T_OFF) > T_TIMEOUT ? (T_ON > T_OFF ? T_ON : T_OFF) : T_TIMEOUT;
  localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] ON_TC  = TW'(T_ON - 1);
  localparam logic [TW-1:0] OFF_TC = TW'(T_OFF - 1);
  localparam logic [TW-1:0] TO_TC  = TW'(T_TIMEOUT - 1);
  state_e     state_d, state_q;
  logic [3:0] idx_d, idx_q, rodada_d, rodada_q, seq_addr_d, seq_addr_q, leds_d, leds_q, off_next;
  logic       gap_d, gap_q, erro_d, erro_q, vitoria_d, vitoria_q;
  logic       tc, press, idle, tmr_clr;
  logic [TW-1:0] term;
  assign press = state_q == ESPERA && botoes != 4'b0;
  assign idle  = state_q == OCIOSO || state_q == GANHOU || state_q == PERDEU;
  assign term  = state_q == MOSTRA_ON ? ON_TC : state_q == MOSTRA_OFF ? OFF_TC : TO_TC;
  assign tmr_clr = idle || press || state_d != state_q;
  genius_timer #(.W(TW)) u_timer (
    .clock (clock),
    .reset (reset),
    .clr   (tmr_clr),
    .ld    (1'b0),
    .en    (1'b1),
    .ld_val('0),
    .term  (term),
    .tc    (tc)
  );
  // next state; gap_q marks the dark gap before a replay, which restarts at step 0
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rodada_d = rodada_q;
    gap_d    = gap_q;
    unique case (state_q)
      OCIOSO, GANHOU, PERDEU: if (start) begin
        state_d  = MOSTRA_ON;
        idx_d    = '0;
        rodada_d = '0;
        gap_d    = 1'b0;
      end
      MOSTRA_ON: if (tc) state_d = MOSTRA_OFF;
      MOSTRA_OFF: if (tc) begin
        gap_d = 1'b0;
        if (gap_q) state_d = MOSTRA_ON;
        else if (idx_q < rodada_q) begin
          idx_d   = idx_q + 4'd1;
          state_d = MOSTRA_ON;
        end else begin
          idx_d   = '0;
          state_d = ESPERA;
        end
      end
      ESPERA: if (press) begin
        if (botoes != seq_data) state_d = PERDEU;
        else if (idx_q < rodada_q) idx_d = idx_q + 4'd1;
        else if (rodada_q < LAST_ROUND) begin
          rodada_d = rodada_q + 4'd1;
          idx_d    = '0;
          gap_d    = 1'b1;
          state_d  = MOSTRA_OFF;
        end else state_d = GANHOU;
      end else if (tc) state_d = PERDEU;
      default: state_d = OCIOSO;
    endcase
  end
  // outputs from the next state; while dark the ROM address already points at the next step shown
  always_comb begin
    off_next   = gap_d ? 4'd0 : idx_d < rodada_d ? idx_d + 4'd1 : 4'd0;
    seq_addr_d = (state_d == MOSTRA_ON || state_d == ESPERA) ? idx_d : state_d == MOSTRA_OFF ? off_next : 4'd0;
    leds_d     = state_d == MOSTRA_ON ? seq_data
               : (state_d == ESPERA && state_q == ESPERA) ? botoes
               : state_d == GANHOU ? TODAS : 4'b0;
    erro_d     = state_d == PERDEU;
    vitoria_d  = state_d == GANHOU;
  end
  // state and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= OCIOSO;
      idx_q      <= '0;
      rodada_q   <= '0;
      gap_q      <= 1'b0;
      seq_addr_q <= '0;
      leds_q     <= '0;
      erro_q     <= 1'b0;
      vitoria_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rodada_q   <= rodada_d;
      gap_q      <= gap_d;
      seq_addr_q <= seq_addr_d;
      leds_q     <= leds_d;
      erro_q     <= erro_d;
      vitoria_q  <= vitoria_d;
    end
  end
  assign seq_addr = seq_addr_q;
  assign leds     = leds_q;
  assign rodada   = rodada_q;
  assign erro     = erro_q;
  assign vitoria  = vitoria_q;
endmodule

// File: doc/genius_ctrl.md
GENIUS_CTRL -- requirements
Module: genius_ctrl

Interface
REQ-001 Parameter T_ON, default 25_000_000, clock cycles each sequence LED is lit during playback.
REQ-002 Parameter T_OFF, default 12_500_000, dark clock cycles between playback steps.
REQ-003 Parameter T_TIMEOUT, default 250_000_000, maximum idle clock cycles allowed per player input.
REQ-004 The port list SHALL be exactly the following ports, in this order:
- clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a game.
- botoes  in  4  player buttons, one-hot, debounced, single-cycle pulse per press.
- seq_data  in  4  one-hot colour from the external combinational sequence ROM for the current seq_addr.
- seq_addr  out  4  step index driven to the sequence ROM.
- leds  out  4  lamp outputs.
- rodada  out  4  current round; round n requires n+1 steps.
- erro  out  1  high while in state PERDEU.
- vitoria  out  1  high while in state GANHOU.

Function
REQ-005 The controller SHALL implement the states OCIOSO, MOSTRA_ON, MOSTRA_OFF, ESPERA, GANHOU and PERDEU.
REQ-006 All outputs SHALL be registered; seq_data SHALL be sampled in the same cycle seq_addr presents its address.
REQ-007 OCIOSO: leds=0; start=1 -> MOSTRA_ON next cycle with rodada=0, idx=0, timer=0.
REQ-008 MOSTRA_ON: seq_addr=idx, leds=seq_data for exactly T_ON cycles, then -> MOSTRA_OFF with timer cleared.
REQ-009 MOSTRA_OFF: leds=0 for exactly T_OFF cycles.
REQ-010 End of MOSTRA_OFF with idx<rodada: idx++ and -> MOSTRA_ON.
REQ-011 End of MOSTRA_OFF with idx==rodada: idx=0, timer=0 and -> ESPERA.
REQ-012 ESPERA: seq_addr=idx; leds=botoes, registered, so the echo lags the press by one cycle.
REQ-013 ESPERA, press (botoes!=0) with botoes==seq_data and idx<rodada: idx++, timer=0, stay in ESPERA.
REQ-014 ESPERA, matching press with idx==rodada and rodada<15: rodada++, idx=0 and -> MOSTRA_OFF, giving a dark gap before replay.
REQ-015 ESPERA, matching press with idx==rodada==15: -> GANHOU.
REQ-016 ESPERA, any press with botoes!=seq_data, including multi-hot values: -> PERDEU.
REQ-017 ESPERA with botoes==0: timer increments; when timer reaches T_TIMEOUT-1, -> PERDEU.
REQ-018 Button pulses outside ESPERA SHALL be ignored.
REQ-019 GANHOU: leds=4'b1111, vitoria=1, rodada held at 15.
REQ-020 PERDEU: leds=0, erro=1, rodada held at its failing value.
REQ-021 start=1 in GANHOU or PERDEU SHALL restart exactly as from OCIOSO.
REQ-022 start SHALL be ignored in MOSTRA_ON, MOSTRA_OFF and ESPERA.
REQ-023 rodada SHALL never wrap past 15; idx SHALL never exceed rodada.
REQ-024 The timer SHALL be sized to ceil(log2(max(T_ON, T_OFF, T_TIMEOUT))) bits.

Reset
REQ-025 reset=1 SHALL take priority over every other input at any point, including mid-playback or mid-input.
REQ-026 On the next edge after reset=1 the block SHALL be in OCIOSO with leds=0, seq_addr=0, rodada=0, erro=0, vitoria=0, idx=0 and timer=0.

Structure
REQ-027 A shared package genius_pkg SHALL hold the state enumeration, the colour constants (VERDE=0001, VERMELHO=0010, AZUL=0100, AMARELO=1000) and LAST_ROUND=15.
REQ-028 The block SHALL contain a single sub-module, genius_timer: a loadable up-counter with clear and terminal-count compare.
REQ-029 The sequence ROM SHALL remain external, attached only through seq_addr and seq_data.

Verification
The bench SHALL use T_ON=2, T_OFF=1, T_TIMEOUT=8, and a ROM model returning 0001 at address 0, 0100 at 1 and 0010 at 2.
REQ-030 Reset during MOSTRA_ON -> next cycle OCIOSO, all outputs 0.
REQ-031 start -> leds=0001 for 2 cycles, then 0 for 1 cycle, then ESPERA with seq_addr=0.
REQ-032 Round 0, press 0001 -> rodada=1; playback 0001, dark, 0100.
REQ-033 Round 1, press 0001 then 0100 -> rodada=2.
REQ-034 Round 1, press 0001 then 0010 -> erro=1, leds=0, rodada=1.
REQ-035 In ESPERA with no press for 8 cycles -> PERDEU.
REQ-036 In ESPERA, press 0011 -> PERDEU.
REQ-037 Full 16-round correct play -> vitoria=1, leds=1111; a subsequent start -> rodada=0 and playback restarts.
